// File: rtl/mult_unit_wb_if.sv
// Multiply-unit bus: request from execute, writeback strobe, and the
// high/low product pair presented to the register bank (r19/r20).
//   master: execute/bank side (drives start, operands, is_signed, wb_we)
//   slave : multiplier side (drives busy, done, mult_flag, high, low)
interface mult_unit_wb_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             is_signed;
  logic             wb_we;
  logic             busy;
  logic             done;
  logic             mult_flag;
  logic [WIDTH-1:0] high;
  logic [WIDTH-1:0] low;

  modport master (
    output start, mul_a, mul_b, is_signed, wb_we,
    input  busy, done, mult_flag, high, low
  );

  modport slave (
    input  start, mul_a, mul_b, is_signed, wb_we,
    output busy, done, mult_flag, high, low
  );
endinterface

// File: rtl/mult_unit_wb.sv
// Iterative shift-add WIDTHxWIDTH multiplier feeding the register bank's
// multiply write path (high -> r19, low -> r20 on a mult_flag edge).
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - mult_unit_wb_if.slave: start/mul_a/mul_b/is_signed/wb_we in,
//          busy/done/mult_flag/high/low out
// busy, done and mult_flag are decoded from the registered state (done and
// mult_flag also gated by wb_we, which has priority in the bank).
// Optional build macro MULT_EARLY_EXIT_EN: finish RUN as soon as the
// remaining multiplier bits are zero, aligning the accumulator in one shift.
module mult_unit_wb #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  mult_unit_wb_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] low_q, low_d;

  logic [WIDTH:0]   sum;
  logic [PW-1:0]    shifted;
  logic [PW-1:0]    aligned;
  logic [PW-1:0]    prod;
  logic             last;
  logic             mflag_c;
`ifdef MULT_EARLY_EXIT_EN
  logic [WIDTH-1:0] rem_mask;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      high_q   <= '0;
      low_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      high_q   <= high_d;
      low_q    <= low_d;
    end
  end

  // Next-state, datapath step and write strobe
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    high_d   = high_q;
    low_d    = low_q;
    sum      = '0;
    shifted  = '0;
    aligned  = '0;
    prod     = '0;
    last     = 1'b0;
    mflag_c  = 1'b0;
`ifdef MULT_EARLY_EXIT_EN
    rem_mask = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Magnitudes fit in WIDTH bits unsigned, including the most negative value
          mcand_d  = (bus.is_signed && bus.mul_a[WIDTH-1]) ? (~bus.mul_a + WIDTH'(1)) : bus.mul_a;
          mplier_d = (bus.is_signed && bus.mul_b[WIDTH-1]) ? (~bus.mul_b + WIDTH'(1)) : bus.mul_b;
          neg_d    = bus.is_signed & (bus.mul_a[WIDTH-1] ^ bus.mul_b[WIDTH-1]);
          acc_d    = '0;
          count_d  = CW'(WIDTH);
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        // {carry, acc, multiplier} >> 1; the consumed multiplier LSB drops out
        shifted  = {sum, mplier_q[WIDTH-1:1]};
        acc_d    = shifted[PW-1:WIDTH];
        mplier_d = shifted[WIDTH-1:0];
        count_d  = count_q - CW'(1);
`ifdef MULT_EARLY_EXIT_EN
        // Unshifted multiplier bits sit in [count_q-1:0]; bit 0 is consumed now
        rem_mask = ((WIDTH'(1) << count_q) - WIDTH'(1)) & ~WIDTH'(1);
        last     = (count_q == CW'(1)) || ((mplier_q & rem_mask) == '0);
        aligned  = shifted >> (count_q - CW'(1));
`else
        last     = (count_q == CW'(1));
        aligned  = shifted;
`endif
        if (last) begin
          prod    = neg_q ? (~aligned + PW'(1)) : aligned;
          high_d  = prod[PW-1:WIDTH];
          low_d   = prod[WIDTH-1:0];
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        // Bank's normal writeback wins; hold the product until the port is free
        mflag_c = ~bus.wb_we;
        if (mflag_c) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.mult_flag = mflag_c;
  assign bus.done      = mflag_c;
  assign bus.high      = high_q;
  assign bus.low       = low_q;

endmodule

// File: tb/tb_mult_unit_wb.sv
// Self-checking bench for mult_unit_wb: directed corner cases plus random
// operations compared against an arithmetic reference product and latency.
module tb_mult_unit_wb;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_unit_wb_if #(.WIDTH(W)) bus ();

  mult_unit_wb #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference product from plain 64-bit arithmetic
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Number of RUN cycles expected for this multiplier
  function automatic int run_cycles(input logic [31:0] b, input logic s);
`ifdef MULT_EARLY_EXIT_EN
    logic [31:0] m;
    int r;
    m = (s && b[31]) ? (32'd0 - b) : b;
    r = 1;
    for (int i = 0; i < 32; i++) if (m[i]) r = i + 1;
    return r;
`else
    return (b == b) && (s == s) ? int'(W) : 0;
`endif
  endfunction

  // One operation: start accepted at E0; the write edge is E(run+1+hold).
  // hold: cycles wb_we is held high from WRITE entry.
  // pulse: keep start (with junk operands) asserted while busy.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold, input logic pulse);
    logic [63:0] exp;
    int lat;
    exp = ref_prod(a, b, s);
    lat = run_cycles(b, s) + 1;
    @(negedge clk);
    check_eq("idle_busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b1;
    bus.mul_a = a;
    bus.mul_b = b;
    bus.is_signed = s;
    bus.wb_we = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= lat + hold; k++) begin
      @(negedge clk);
      bus.start = pulse;
      if (pulse) begin
        bus.mul_a = $urandom;
        bus.mul_b = $urandom;
        bus.is_signed = 1'($urandom);
      end
      bus.wb_we = (k >= lat) && (k < lat + hold);
      #1;
      check_eq("busy", 64'(bus.busy), 64'd1);
      check_eq("mult_flag", 64'(bus.mult_flag), 64'(k == lat + hold));
      check_eq("done", 64'(bus.done), 64'(k == lat + hold));
      if (k >= lat) begin
        check_eq("high", 64'(bus.high), 64'(exp[63:32]));
        check_eq("low", 64'(bus.low), 64'(exp[31:0]));
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.wb_we = 1'b0;
    #1;
    check_eq("post_busy", 64'(bus.busy), 64'd0);
    check_eq("post_flag", 64'(bus.mult_flag), 64'd0);
    check_eq("post_high", 64'(bus.high), 64'(exp[63:32]));
    check_eq("post_low", 64'(bus.low), 64'(exp[31:0]));
  endtask

  // Start an operation, then pulse reset after abort_edge RUN edges
  task automatic abort_run(input logic [31:0] a, input logic [31:0] b, input int abort_edge);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mul_a = a;
    bus.mul_b = b;
    bus.is_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (abort_edge) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_busy", 64'(bus.busy), 64'd0);
    check_eq("abort_flag", 64'(bus.mult_flag), 64'd0);
    check_eq("abort_high", 64'(bus.high), 64'd0);
    check_eq("abort_low", 64'(bus.low), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort_idle", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, mask;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.mul_a = '0;
    bus.mul_b = '0;
    bus.is_signed = 1'b0;
    bus.wb_we = 1'b0;
    #12;
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_flag", 64'(bus.mult_flag), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_high", 64'(bus.high), 64'd0);
    check_eq("rst_low", 64'(bus.low), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    do_mult(32'hFFFF_FFFD, 32'd5, 1'b1, 0, 1'b0);
    do_mult(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1'b0);
    do_mult(32'd7, 32'd6, 1'b0, 4, 1'b0);
    do_mult(32'd1000, 32'hFFFF_FFFF, 1'b1, 0, 1'b1);
    do_mult(32'd3, 32'd9, 1'b0, 0, 1'b0);
    abort_run(32'hDEAD_BEEF, 32'hFFFF_FFFF, 22);
    do_mult(32'h0000_1234, 32'h0000_0010, 1'b0, 0, 1'b0);
    do_mult(32'h0000_ABCD, 32'd1, 1'b0, 0, 1'b0);
    do_mult(32'h1234_5678, 32'd0, 1'b1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      mask = 32'hFFFF_FFFF >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rb = rb & mask;
      do_mult(ra, rb, 1'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_unit_wb.md
Name: mult_unit_wb

Overview:
- Iterative shift-add 32x32 multiplier that writes the register bank's multiply path.
- Accepts one multiply request from the execute stage and computes a 64-bit product over WIDTH cycles.
- Presents the product as high/regWriteData with a mult_flag pulse, so the bank stores the high word in r19 and the low word in r20.
- Stalls its write while the normal writeback port is active, because the bank gives regWriteEnable priority over mult_flag.

Parameters:
- WIDTH, 32: operand width. The product is 2*WIDTH bits; the RUN length is WIDTH cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request strobe; sampled only in IDLE.
- mul_a  in  WIDTH  multiplicand, captured on accepted start.
- mul_b  in  WIDTH  multiplier, captured on accepted start.
- is_signed  in  1  1 = two's-complement operands; 0 = unsigned. Captured on start.
- wb_we  in  1  the core's regWriteEnable for the same cycle; blocks the multiply write.
- busy  out  1  high in RUN and WRITE.
- done  out  1  one-cycle pulse, coincident with mult_flag.
- mult_flag  out  1  drives bank mult_flag.
- high  out  WIDTH  product[2W-1:W]; drives bank high.
- low  out  WIDTH  product[W-1:0]; muxed onto bank regWriteData when mult_flag=1.

Behaviour:
- Reset (rst low, async): state=IDLE. busy=0, done=0, mult_flag=0, high=0, low=0. Counter and operand registers cleared.
- IDLE:
  - On an edge with start=1: capture |mul_a| and |mul_b| (magnitudes when is_signed=1, raw otherwise).
  - Record neg = is_signed & (a[W-1]^b[W-1]).
  - Clear the accumulator, load count=WIDTH, go to RUN.
- RUN, one edge per bit:
  - If multiplier LSB=1, add the multiplicand into the upper half of the accumulator, with carry into a W+1-bit sum.
  - Shift the {carry, acc, multiplier} combination right by 1 and decrement count.
  - When count reaches 0, the same edge loads high/low with the product, two's-complement negated over the full 2W bits if neg, and moves to WRITE.
- WRITE:
  - mult_flag = done = (state==WRITE) & ~wb_we. This is combinational from registered state.
  - On an edge with mult_flag=1, go to IDLE. The bank writes r19/r20 on that edge.
  - While wb_we=1, stay in WRITE with high/low held stable. There is no timeout.
- Latency: start accepted at edge E0, state is WRITE after edge E(WIDTH). With wb_we=0 the bank is written at E(WIDTH+1); done is high for the cycle before that edge.
- start while busy is ignored and not queued. Operand inputs are don't-care outside accept.
- high/low keep the last product after returning to IDLE, until the next accept overwrites them at completion.
- Signed edge: 0x80000000 magnitude is 2^31 and must use a W-bit unsigned magnitude without overflow.
- Reset asserted mid-RUN or mid-WRITE: abort immediately. No mult_flag, outputs zero.
- start on the same edge that WRITE→IDLE is not accepted; it is accepted on the next IDLE edge.

Optional Feature:
- Macro MULT_EARLY_EXIT_EN.
- Defined: RUN also ends when the remaining unshifted multiplier bits are all zero. The accumulator is aligned by the remaining count in one shift, then the unit goes to WRITE. Latency becomes 1..WIDTH RUN cycles, with a minimum of 1 RUN cycle even for mul_b=0. Results are identical to the non-early-exit build.
- Undefined: fixed WIDTH RUN cycles and fixed latency.

Test Plan:
- Unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF, is_signed=0, wb_we=0 -> exactly one mult_flag cycle. high=0xFFFFFFFE, low=0x00000001. Write edge is E33 after the start edge E0.
- Signed: a=0xFFFFFFFD (-3), b=5 -> high=0xFFFFFFFF, low=0xFFFFFFF1. Then a=b=0x80000000 signed -> high=0x40000000, low=0x00000000.
- Writeback conflict: a=7, b=6 with wb_we held high for 4 cycles after WRITE entry -> mult_flag=0 for those 4 cycles. mult_flag=1 on the 5th cycle; high=0, low=42 held throughout.
- start pulsed on every cycle during a busy operation -> only the first is accepted. Exactly one done per operation; the next start is accepted after IDLE.
- rst low for 1 cycle at RUN count 10 -> busy, mult_flag, high and low all 0 immediately. No write occurs. A new start afterwards gives the correct product 0x1234*0x10=0x12340 (high=0).
- MULT_EARLY_EXIT_EN defined, a=0xABCD, b=1 -> mult_flag at the second edge after start with low=0xABCD. Same operands with the macro undefined -> same result at E33.
